// File: rtl/defines.sv
// Shared constants and FSM state type for the bumper hit controller.
package defines;

    localparam logic [7:0] BUMPER_FLASH_COLOR = 8'hFF;

    typedef enum logic [1:0] {
        StIdle,
        StFlash,
        StCooldown
    } state_e;

endpackage

// File: rtl/frame_down_counter.sv
// Frame countdown: load has priority over decrement; zero_o flags a count of 0.
module frame_down_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bumper_hit_ctrl.sv
// Bumper hit detection: registered pixel path, per-frame hit evaluation,
// flash/cooldown sequencing and saturating score.
module bumper_hit_ctrl
    import defines::*;
#(
    parameter int unsigned FLASH_FRAMES    = 8,
    parameter int unsigned COOLDOWN_FRAMES = 4,
    parameter int unsigned SCORE_PER_HIT   = 10,
    parameter int unsigned SCORE_WIDTH     = 16
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   startOfFrame,
    input  logic                   drawBall,
    input  logic                   drawBumper,
    input  logic [7:0]             RGBBumper,
    output logic                   drawBumperOut,
    output logic [7:0]             RGBBumperOut,
    output logic                   bumperCollision,
    output logic                   hitPulse,
    output logic [SCORE_WIDTH-1:0] score
);

    localparam logic [7:0] FlashLoad = 8'(FLASH_FRAMES - 1);
    localparam logic [7:0] CoolLoad  = 8'(COOLDOWN_FRAMES - 1);
    localparam logic [SCORE_WIDTH:0] HitInc = (SCORE_WIDTH + 1)'(SCORE_PER_HIT);

    state_e                 state_q, state_d;
    logic                   col_seen_q, col_seen_d;
    logic                   hit_pulse_q, hit_pulse_d;
    logic [SCORE_WIDTH-1:0] score_q, score_d;
    logic                   draw_q;
    logic [7:0]             rgb_q, rgb_d;
    logic                   coll_q;

    logic                   collision;
    logic                   hit_eval;
    logic [SCORE_WIDTH:0]   score_sum;
    logic [SCORE_WIDTH-1:0] score_sat;
    logic                   cnt_load, cnt_dec, cnt_zero;
    logic [7:0]             cnt_load_val;

    assign collision = drawBall & drawBumper;
    // A collision on the startOfFrame cycle still belongs to the closing frame.
    assign hit_eval  = col_seen_q | collision;
    assign score_sum = {1'b0, score_q} + HitInc;
    assign score_sat = score_sum[SCORE_WIDTH] ? '1 : score_sum[SCORE_WIDTH-1:0];

    always_comb begin
        state_d      = state_q;
        col_seen_d   = startOfFrame ? 1'b0 : hit_eval;
        hit_pulse_d  = 1'b0;
        score_d      = score_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (startOfFrame && hit_eval) begin
                    state_d      = StFlash;
                    cnt_load     = 1'b1;
                    cnt_load_val = FlashLoad;
                    hit_pulse_d  = 1'b1;
                    score_d      = score_sat;
                end
            end
            StFlash: begin
                if (startOfFrame) begin
                    if (cnt_zero) begin
                        state_d      = StCooldown;
                        cnt_load     = 1'b1;
                        cnt_load_val = CoolLoad;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            StCooldown: begin
                if (startOfFrame) begin
                    if (cnt_zero) begin
                        state_d = StIdle;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rgb_d = RGBBumper;
        if (state_q == StFlash && drawBumper) begin
            rgb_d = BUMPER_FLASH_COLOR;
        end
    end

    frame_down_counter #(
        .WIDTH (8)
    ) u_frame_cnt (
        .clk_i      (clk),
        .rst_ni     (resetN),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= StIdle;
            col_seen_q  <= 1'b0;
            hit_pulse_q <= 1'b0;
            score_q     <= '0;
            draw_q      <= 1'b0;
            rgb_q       <= 8'h00;
            coll_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_seen_q  <= col_seen_d;
            hit_pulse_q <= hit_pulse_d;
            score_q     <= score_d;
            draw_q      <= drawBumper;
            rgb_q       <= rgb_d;
            coll_q      <= collision;
        end
    end

    assign drawBumperOut   = draw_q;
    assign RGBBumperOut    = rgb_q;
    assign bumperCollision = coll_q;
    assign hitPulse        = hit_pulse_q;
    assign score           = score_q;

endmodule

// File: tb/tb_bumper_hit_ctrl.sv
// Directed bench for bumper_hit_ctrl; a second instance with a 4-bit score checks saturation.
module tb_bumper_hit_ctrl;

    localparam int FRAME_LEN = 12;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic        drawBall;
    logic        drawBumper;
    logic [7:0]  RGBBumper;

    logic        drawBumperOut, bumperCollision, hitPulse;
    logic [7:0]  RGBBumperOut;
    logic [15:0] score;

    logic        s_drawBumperOut, s_bumperCollision, s_hitPulse;
    logic [7:0]  s_RGBBumperOut;
    logic [3:0]  s_score;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bumper_hit_ctrl dut (
        .clk             (clk),
        .resetN          (resetN),
        .startOfFrame    (startOfFrame),
        .drawBall        (drawBall),
        .drawBumper      (drawBumper),
        .RGBBumper       (RGBBumper),
        .drawBumperOut   (drawBumperOut),
        .RGBBumperOut    (RGBBumperOut),
        .bumperCollision (bumperCollision),
        .hitPulse        (hitPulse),
        .score           (score)
    );

    bumper_hit_ctrl #(
        .SCORE_WIDTH (4)
    ) dut_small (
        .clk             (clk),
        .resetN          (resetN),
        .startOfFrame    (startOfFrame),
        .drawBall        (drawBall),
        .drawBumper      (drawBumper),
        .RGBBumper       (RGBBumper),
        .drawBumperOut   (s_drawBumperOut),
        .RGBBumperOut    (s_RGBBumperOut),
        .bumperCollision (s_bumperCollision),
        .hitPulse        (s_hitPulse),
        .score           (s_score)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One frame: bumper pixel (RGB 3C) at cycle 5, optional ball/bumper overlap at cycle 'hit'.
    task automatic do_frame(input string tag, input int hit, input int exp_pulses,
                            input logic [7:0] exp_rgb);
        int         pulses = 0;
        logic       p0     = 1'b0;
        logic [7:0] rgb5   = 8'h00;
        logic       coll   = 1'b0;
        for (int i = 0; i < FRAME_LEN; i++) begin
            startOfFrame = (i == 0);
            drawBall     = (i == hit);
            drawBumper   = (i == 5) || (i == hit);
            RGBBumper    = (i == 5) ? 8'h3C : 8'h5A;
            step();
            if (hitPulse) pulses++;
            if (i == 0) p0 = hitPulse;
            if (i == 5) rgb5 = RGBBumperOut;
            if (i == hit) coll = bumperCollision;
        end
        check_eq({tag, " pulses"}, pulses, exp_pulses);
        if (exp_pulses > 0) check_eq({tag, " pulse_timing"}, {31'd0, p0}, 1);
        check_eq({tag, " rgb"}, {24'd0, rgb5}, {24'd0, exp_rgb});
        if (hit >= 0) check_eq({tag, " collision"}, {31'd0, coll}, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       pd;
        logic [7:0] pr;
        int         hit;
        int         exp_p;
        logic [7:0] exp_rgb;

        resetN       = 1'b0;
        startOfFrame = 1'b0;
        drawBall     = 1'b0;
        drawBumper   = 1'b0;
        RGBBumper    = 8'h00;
        #12;
        check_eq("rst drawBumperOut", {31'd0, drawBumperOut}, 0);
        check_eq("rst RGBBumperOut", {24'd0, RGBBumperOut}, 0);
        check_eq("rst bumperCollision", {31'd0, bumperCollision}, 0);
        check_eq("rst hitPulse", {31'd0, hitPulse}, 0);
        check_eq("rst score", {16'd0, score}, 0);
        check_eq("rst small score", {28'd0, s_score}, 0);
        @(negedge clk);
        resetN = 1'b1;
        step();

        // Pass-through with no ball: outputs are inputs delayed one cycle.
        for (int i = 0; i < 40; i++) begin
            startOfFrame = ($urandom_range(0, 3) == 0);
            drawBall     = 1'b0;
            drawBumper   = 1'($urandom);
            RGBBumper    = 8'($urandom);
            pd = drawBumper;
            pr = RGBBumper;
            step();
            check_eq("pt drawBumperOut", {31'd0, drawBumperOut}, {31'd0, pd});
            check_eq("pt RGBBumperOut", {24'd0, RGBBumperOut}, {24'd0, pr});
            check_eq("pt bumperCollision", {31'd0, bumperCollision}, 0);
        end
        check_eq("pt score", {16'd0, score}, 0);

        // Hits in frames 0,3,10,13: only 0 and 13 score; flash frames 1..8 and 14.
        for (int f = 0; f <= 14; f++) begin
            hit     = (f == 0 || f == 3 || f == 10 || f == 13) ? 8 : -1;
            exp_p   = (f == 1 || f == 14) ? 1 : 0;
            exp_rgb = ((f >= 1 && f <= 8) || f == 14) ? 8'hFF : 8'h3C;
            do_frame($sformatf("f%0d", f), hit, exp_p, exp_rgb);
            if (f == 1) begin
                check_eq("f1 score", {16'd0, score}, 10);
                check_eq("f1 small score", {28'd0, s_score}, 10);
            end
        end
        check_eq("f14 score", {16'd0, score}, 20);
        check_eq("f14 small score sat", {28'd0, s_score}, 15);

        do_frame("f15", -1, 0, 8'hFF);

        // Flash frame 3: reset asynchronously mid-cycle.
        startOfFrame = 1'b1;
        drawBall     = 1'b0;
        drawBumper   = 1'b0;
        step();
        startOfFrame = 1'b0;
        drawBall     = 1'b1;
        drawBumper   = 1'b1;
        RGBBumper    = 8'h3C;
        step();
        check_eq("f16 pre-rst rgb", {24'd0, RGBBumperOut}, 8'hFF);
        check_eq("f16 pre-rst drawBumperOut", {31'd0, drawBumperOut}, 1);
        check_eq("f16 pre-rst collision", {31'd0, bumperCollision}, 1);
        #2;
        resetN = 1'b0;
        #1;
        check_eq("arst drawBumperOut", {31'd0, drawBumperOut}, 0);
        check_eq("arst RGBBumperOut", {24'd0, RGBBumperOut}, 0);
        check_eq("arst bumperCollision", {31'd0, bumperCollision}, 0);
        check_eq("arst hitPulse", {31'd0, hitPulse}, 0);
        check_eq("arst score", {16'd0, score}, 0);
        check_eq("arst small score", {28'd0, s_score}, 0);
        drawBall   = 1'b0;
        drawBumper = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetN = 1'b1;

        do_frame("r0", 8, 0, 8'h3C);
        do_frame("r1", -1, 1, 8'hFF);
        check_eq("r1 score", {16'd0, score}, 10);
        check_eq("r1 small score", {28'd0, s_score}, 10);
        for (int r = 2; r <= 13; r++) begin
            do_frame($sformatf("r%0d", r), -1, 0, (r <= 8) ? 8'hFF : 8'h3C);
        end
        // Overlap only on the startOfFrame cycle counts for the frame just closed.
        do_frame("r14", 0, 1, 8'hFF);
        check_eq("r14 score", {16'd0, score}, 20);
        check_eq("r14 small score sat", {28'd0, s_score}, 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bumper_hit_ctrl.md
BUMPER_HIT_CTRL -- requirements
Module: bumper_hit_ctrl

Interface
REQ-001 The module SHALL have parameter FLASH_FRAMES, default 8, giving frames the bumper flashes after a hit (legal range 1..255).
REQ-002 The module SHALL have parameter COOLDOWN_FRAMES, default 4, giving frames after the flash during which hits are ignored (legal range 1..255).
REQ-003 The module SHALL have parameter SCORE_PER_HIT, default 10, giving the score increment per accepted hit.
REQ-004 The module SHALL have parameter SCORE_WIDTH, default 16, giving the score width in bits.
REQ-005 Port clk, input, 1: the single system clock; all state SHALL be clocked on its rising edge.
REQ-006 Port resetN, input, 1: asynchronous active-low reset.
REQ-007 Port startOfFrame, input, 1: one-cycle pulse at the first pixel of each frame.
REQ-008 Port drawBall, input, 1: the ball covers the current pixel.
REQ-009 Port drawBumper, input, 1: a bumper covers the current pixel (upstream bumper block).
REQ-010 Port RGBBumper, input, 8: bumper colour for the current pixel (upstream).
REQ-011 Port drawBumperOut, output, 1: registered drawBumper toward the display mux.
REQ-012 Port RGBBumperOut, output, 8: registered, flash-modified bumper colour.
REQ-013 Port bumperCollision, output, 1: registered (drawBall & drawBumper), for ball physics.
REQ-014 Port hitPulse, output, 1: one-cycle pulse when a hit is accepted.
REQ-015 Port score, output, SCORE_WIDTH: accumulated bumper score.

Function
REQ-016 The pixel path SHALL have exactly 1 clk latency: drawBumperOut, RGBBumperOut and bumperCollision SHALL reflect the inputs of the previous cycle.
REQ-017 The module SHALL set a sticky flag colSeen in any cycle where drawBall & drawBumper = 1.
REQ-018 On startOfFrame, the module SHALL evaluate colSeen OR-ed with that cycle's collision, then clear colSeen; a collision coinciding with startOfFrame SHALL count toward the closing frame.
REQ-019 The FSM SHALL have exactly three states: IDLE, FLASH and COOLDOWN.
REQ-020 In IDLE, on startOfFrame with collision evaluated true, the FSM SHALL go to FLASH, load frameCnt = FLASH_FRAMES-1, assert hitPulse on the next cycle for exactly 1 cycle, and add SCORE_PER_HIT to score.
REQ-021 Score SHALL saturate at 2^SCORE_WIDTH-1 and SHALL never wrap.
REQ-022 In FLASH, RGBBumperOut SHALL equal BUMPER_FLASH_COLOR whenever the registered drawBumper = 1; otherwise it SHALL equal the registered RGBBumper.
REQ-023 In FLASH, on each startOfFrame, frameCnt SHALL decrement; on startOfFrame with frameCnt = 0, the FSM SHALL go to COOLDOWN and load frameCnt = COOLDOWN_FRAMES-1.
REQ-024 In COOLDOWN, colour SHALL pass through; on startOfFrame with frameCnt = 0, the FSM SHALL go to IDLE, else frameCnt SHALL decrement.
REQ-025 Collisions in FLASH or COOLDOWN SHALL NOT score or pulse, and SHALL be discarded at the next startOfFrame.
REQ-026 bumperCollision SHALL be driven in every state, independent of the FSM.
REQ-027 startOfFrame on two consecutive cycles SHALL be treated as two frames, with no special casing.

Reset
REQ-028 While resetN = 0, state SHALL be IDLE; colSeen, frameCnt, score, hitPulse, bumperCollision and drawBumperOut SHALL be 0; RGBBumperOut SHALL be 8'h00.
REQ-029 A reset asserted mid-FLASH SHALL abort the flash immediately and clear score; the first frame after release SHALL behave as IDLE.

Structure
REQ-030 BUMPER_FLASH_COLOR (8'hFF) and the FSM state enum type SHALL live in package defines.
REQ-031 The frame countdown SHALL be one sub-module, frame_down_counter (load, decrement-on-startOfFrame, zero flag), reused for both FLASH and COOLDOWN.

Verification
REQ-032 Scenario: one overlap pixel in frame 0 -> hitPulse 1 cycle after the next startOfFrame; score = 10; flash colour 8'hFF for exactly 8 frames, then 4 frames pass-through.
REQ-033 Scenario: overlaps in frames 0, 3 and 10 (defaults) -> only frame 0 scores; frame 13 overlap scores; score = 20.
REQ-034 Scenario: overlap only on the startOfFrame cycle -> counted to the prior frame; hitPulse asserts.
REQ-035 Scenario: SCORE_WIDTH = 4, 2 hits -> score saturates at 15, never 4.
REQ-036 Scenario: resetN low in flash frame 3 -> all outputs 0 asynchronously; after release, pass-through colour and a fresh hit scores 10.
REQ-037 Scenario: random drawBumper/RGBBumper with drawBall = 0 -> outputs equal the inputs delayed 1 cycle; score stays 0.
